// File: rtl/window_feeder.sv
// window_feeder: 3x3 sliding-window generator over a row-major 10-bit pixel stream.
// Latency: a window appears on o_busData one cycle after its completing pixel is accepted.
// Backpressure: o_ready = !o_valid || i_ready; a stalled window holds and blocks input.
// Option: define WINDOW_FEEDER_STRIDE2_EN to emit only windows with even (row-2) and (col-2).
module window_feeder #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [89:0] o_busData,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {S_FILL, S_STREAM} state_t;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [9:0]    r_lb0 [IMG_W];
    logic [9:0]    r_lb1 [IMG_W];
    logic [9:0]    r_win [9];
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    state_t        r_state;

    logic          w_accept;
    logic          w_col_last;
    logic          w_frame_last;
    logic          w_emit;
    logic [9:0]    w_top;
    logic [9:0]    w_mid;
    logic [9:0]    w_win_next [9];
    logic [89:0]   w_bus_next;

    assign o_ready      = !o_valid || i_ready;
    assign w_accept     = i_valid && o_ready;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_frame_last = w_col_last && (r_row == ROW_LAST);
    assign w_top        = r_lb1[r_col];
    assign w_mid        = r_lb0[r_col];

    // Row parity equals (row-2) parity, so stride-2 only needs the low bits.
`ifdef WINDOW_FEEDER_STRIDE2_EN
    assign w_emit = (r_state == S_STREAM) && (r_col >= CW'(2)) && !r_col[0] && !r_row[0];
`else
    assign w_emit = (r_state == S_STREAM) && (r_col >= CW'(2));
`endif

    // Next window: shift every row left and append the new column (oldest row on top).
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win_next[r*3 + 0] = r_win[r*3 + 1];
            w_win_next[r*3 + 1] = r_win[r*3 + 2];
            w_win_next[r*3 + 2] = r_win[r*3 + 2];
        end
        w_win_next[2] = w_top;
        w_win_next[5] = w_mid;
        w_win_next[8] = i_data;
    end

    // Flatten the next window, element k at bits [10k+9:10k].
    always_comb begin
        w_bus_next = '0;
        for (int k = 0; k < 9; k++) begin
            w_bus_next[10*k +: 10] = w_win_next[k];
        end
    end

    // Pixel storage; deliberately not reset so a new frame simply overwrites it.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept) begin
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= i_data;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= w_win_next[k];
            end
        end
    end

    // Raster position counters and FILL/STREAM state, advanced per accepted pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_FILL;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (r_row == ROW_LAST) r_row <= '0;
                else                   r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            case (r_state)
                S_FILL:   if (w_col_last && (r_row == RW'(1))) r_state <= S_STREAM;
                S_STREAM: if (w_frame_last) r_state <= S_FILL;
                default:  r_state <= S_FILL;
            endcase
        end
    end

    // Single output stage: load on a completing accept, drop valid on a bare consume.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busData    <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= w_accept && w_frame_last;
            if (w_accept && w_emit) begin
                o_busData <= w_bus_next;
                o_valid   <= 1'b1;
            end else if (i_ready) begin
                o_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: directed scoreboard bench for window_feeder.
// Expected windows come from an image model filled as pixels are accepted.
// Build with WINDOW_FEEDER_STRIDE2_EN defined to exercise the stride-2 variant.
module tb_window_feeder;
`ifdef WINDOW_FEEDER_STRIDE2_EN
    localparam int W = 7;
    localparam int H = 5;
`else
    localparam int W = 5;
    localparam int H = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  din;
    logic        din_vld;
    logic        din_rdy;
    logic [89:0] bus;
    logic        bus_vld;
    logic        bus_rdy;
    logic        frame_done;

    always #5 clk = ~clk;

    window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (din),
        .i_valid      (din_vld),
        .o_ready      (din_rdy),
        .o_busData    (bus),
        .o_valid      (bus_vld),
        .i_ready      (bus_rdy),
        .o_frame_done (frame_done)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [89:0] exp_q [$];
    logic [89:0] got   [$];
    logic [89:0] ref_q [$];
    int          img [H][W];
    int          m_row = 0;
    int          m_col = 0;
    logic        fd_exp = 1'b0;
    int          fd_count = 0;
    logic        accepted = 1'b0;

    function automatic logic [89:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5,
                                       input int e6, input int e7, input int e8);
        int a [9];
        logic [89:0] w;
        a = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        w = '0;
        for (int k = 0; k < 9; k++) w[10*k +: 10] = 10'(a[k]);
        return w;
    endfunction

    task automatic cmp(input string tag, input logic [89:0] obs, input logic [89:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Model: record the pixel, queue a window if one completes, advance raster position.
    task automatic model_accept(input logic [9:0] v);
        logic [89:0] w;
        logic        ok;
        img[m_row][m_col] = int'(v);
`ifdef WINDOW_FEEDER_STRIDE2_EN
        ok = ((m_row - 2) % 2 == 0) && ((m_col - 2) % 2 == 0);
`else
        ok = 1'b1;
`endif
        if (m_row >= 2 && m_col >= 2 && ok) begin
            w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[10*(r*3+c) +: 10] = 10'(img[m_row-2+r][m_col-2+c]);
            exp_q.push_back(w);
        end
        if (m_col == W - 1) begin
            m_col = 0;
            if (m_row == H - 1) begin
                m_row  = 0;
                fd_exp = 1'b1;
            end else begin
                m_row++;
            end
        end else begin
            m_col++;
        end
    endtask

    // Observe at the falling edge: frame_done, consumed window, accepted pixel.
    task automatic check();
        logic [89:0] e;
        cmp("frame_done", 90'(frame_done), 90'(fd_exp));
        if (frame_done === 1'b1) fd_count++;
        fd_exp = 1'b0;
        if (bus_vld === 1'b1 && bus_rdy) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL window_unexpected observed=%h expected=none", bus);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("window", bus, e);
            end
            got.push_back(bus);
        end
        accepted = 1'b0;
        if (din_vld && din_rdy === 1'b1) begin
            accepted = 1'b1;
            model_accept(din);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input int v);
        int n;
        din      = 10'(v);
        din_vld  = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        assert (accepted) else begin
            errors++;
            $error("FAIL accept_timeout observed=0 expected=1 pixel=%0d", v);
        end
        din_vld = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send_pixel(v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        cmp("drain_empty", 90'(exp_q.size()), 90'(0));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        din_vld = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_row  = 0;
        m_col  = 0;
        fd_exp = 1'b0;
        exp_q.delete();
    endtask

`ifdef WINDOW_FEEDER_STRIDE2_EN
    int centres [6] = '{8, 10, 12, 22, 24, 26};
`endif

    initial begin
        logic [89:0] first_w;
        logic [89:0] last_w;
        logic [89:0] tmp;
        rst     = 1'b1;
        din     = '0;
        din_vld = 1'b0;
        bus_rdy = 1'b1;
        do_reset();
        cmp("rst_o_valid", 90'(bus_vld), 90'(0));
        cmp("rst_busData", bus, 90'(0));
        cmp("rst_frame_done", 90'(frame_done), 90'(0));
        cmp("rst_o_ready", 90'(din_rdy), 90'(1));

`ifdef WINDOW_FEEDER_STRIDE2_EN
        got.delete();
        send_range(0, W*H - 1);
        drain();
        cmp("s2_count", 90'(got.size()), 90'(6));
        for (int k = 0; k < 6; k++) begin
            tmp = got[k];
            cmp("s2_centre", 90'(tmp[49:40]), 90'(centres[k]));
        end
`else
        first_w = pk(0, 1, 2, 5, 6, 7, 10, 11, 12);
        last_w  = pk(7, 8, 9, 12, 13, 14, 17, 18, 19);

        // Single frame with explicit latency checks around pixel 12.
        got.delete();
        fd_count = 0;
        send_range(0, 11);
        cmp("t1_no_early_window", 90'(bus_vld), 90'(0));
        send_pixel(12);
        cmp("t1_first_valid", 90'(bus_vld), 90'(1));
        cmp("t1_first_bus", bus, first_w);
        send_range(13, 19);
        drain();
        cmp("t1_count", 90'(got.size()), 90'(6));
        cmp("t1_first", got[0], first_w);
        cmp("t1_last", got[got.size()-1], last_w);
        cmp("t1_frame_done", 90'(fd_count), 90'(1));
        ref_q = got;

        // Consumer stalls for 3 cycles on the first window.
        got.delete();
        send_range(0, 12);
        bus_rdy = 1'b0;
        din     = 10'd13;
        din_vld = 1'b1;
        repeat (3) begin
            tick();
            cmp("t2_hold_bus", bus, first_w);
            cmp("t2_hold_valid", 90'(bus_vld), 90'(1));
            cmp("t2_o_ready_low", 90'(din_rdy), 90'(0));
        end
        bus_rdy = 1'b1;
        send_range(13, 19);
        drain();
        cmp("t2_count", 90'(got.size()), 90'(6));
        cmp("t2_first", got[0], first_w);
        cmp("t2_last", got[got.size()-1], last_w);

        // Two frames back to back.
        got.delete();
        fd_count = 0;
        send_range(0, 19);
        send_range(100, 119);
        drain();
        cmp("t3_count", 90'(got.size()), 90'(12));
        cmp("t3_f2_first", got[6], pk(100, 101, 102, 105, 106, 107, 110, 111, 112));
        cmp("t3_f2_last", got[11], pk(107, 108, 109, 112, 113, 114, 117, 118, 119));
        cmp("t3_frame_done", 90'(fd_count), 90'(2));

        // Reset mid-frame, then a full frame.
        got.delete();
        send_range(0, 11);
        do_reset();
        cmp("t4_rst_valid", 90'(bus_vld), 90'(0));
        cmp("t4_rst_bus", bus, 90'(0));
        send_range(0, 19);
        drain();
        cmp("t4_count", 90'(got.size()), 90'(6));
        cmp("t4_first", got[0], first_w);
        cmp("t4_last", got[got.size()-1], last_w);

        // Random input gaps: window sequence must match the uninterrupted frame.
        got.delete();
        for (int v = 0; v < 20; v++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_pixel(v);
        end
        drain();
        cmp("t5_count", 90'(got.size()), 90'(6));
        for (int k = 0; k < 6; k++) cmp("t5_seq", got[k], ref_q[k]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
